// File: rtl/rv_rr_dispatcher_if.sv
// ---------------------------------------------------------------------
// rv_rr_dispatcher_if : stream-in / N-channel-out bundle for the dispatcher
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

interface rv_rr_dispatcher_if #(
  parameter int NUM_OUTS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOG_NUM_OUTS = $clog2(NUM_OUTS)
);
  logic                           flush;
  logic                           valid_in;
  logic [DATA_WIDTH-1:0]          data_in;
  logic                           ready_in;
  logic [NUM_OUTS-1:0]            valid_out;
  logic [NUM_OUTS*DATA_WIDTH-1:0] data_out;
  logic [NUM_OUTS-1:0]            ready_out;
  logic [LOG_NUM_OUTS-1:0]        last_index;

  // master: producer plus consumers around the dispatcher
  modport master (
    output flush, valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, last_index
  );

  modport slave (
    input  flush, valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, last_index
  );
endinterface

`default_nettype wire

// File: rtl/rv_rr_dispatcher.sv
// ---------------------------------------------------------------------
// rv_rr_dispatcher : spreads one valid/ready stream round-robin over
// NUM_OUTS registered output slots, skipping slots that cannot take a beat
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module rv_rr_dispatcher #(
  parameter int NUM_OUTS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOG_NUM_OUTS = $clog2(NUM_OUTS)
) (
  input  logic               clk,
  input  logic               reset,
  rv_rr_dispatcher_if.slave  bus
);

  localparam logic [LOG_NUM_OUTS-1:0] LAST_IDX = LOG_NUM_OUTS'(NUM_OUTS - 1);
  localparam logic [LOG_NUM_OUTS:0]   N_WIDE   = (LOG_NUM_OUTS + 1)'(NUM_OUTS);

  logic [NUM_OUTS-1:0]            valid_q, valid_d;
  logic [NUM_OUTS*DATA_WIDTH-1:0] data_q, data_d;
  logic [LOG_NUM_OUTS-1:0]        ptr_q, ptr_d;
  logic [LOG_NUM_OUTS-1:0]        last_q, last_d;

  logic [NUM_OUTS-1:0]            free;
  logic [LOG_NUM_OUTS-1:0]        grant;
  logic [LOG_NUM_OUTS:0]          cand;
  logic                           fire;

  // a slot draining this cycle is reusable in the same cycle
  assign free        = ~valid_q | bus.ready_out;
  assign bus.ready_in = |free;
  assign fire        = bus.valid_in & bus.ready_in;

  // walk offsets from the far end so the closest free slot to ptr wins
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int k = NUM_OUTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (LOG_NUM_OUTS + 1)'(k);
      if (cand >= N_WIDE) begin
        cand = cand - N_WIDE;
      end
      if (free[cand[LOG_NUM_OUTS-1:0]]) begin
        grant = cand[LOG_NUM_OUTS-1:0];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    if (bus.flush) begin
      valid_d = '0;
      ptr_d   = '0;
      last_d  = '0;
    end else begin
      for (int i = 0; i < NUM_OUTS; i++) begin
        if (valid_q[i] && bus.ready_out[i]) begin
          valid_d[i] = 1'b0;
        end
        if (fire && (grant == LOG_NUM_OUTS'(i))) begin
          valid_d[i]                        = 1'b1;
          data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
        end
      end
      if (fire) begin
        ptr_d  = (grant == LAST_IDX) ? '0 : grant + 1'b1;
        last_d = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.data_out   = data_q;
  assign bus.last_index = last_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_rr_dispatcher.sv
// ---------------------------------------------------------------------
// tb_rv_rr_dispatcher : directed stimulus against a queue-level slot model
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_rv_rr_dispatcher;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rv_rr_dispatcher_if #(.NUM_OUTS(4), .DATA_WIDTH(32)) b4 ();
  rv_rr_dispatcher_if #(.NUM_OUTS(3), .DATA_WIDTH(8))  b3 ();

  rv_rr_dispatcher #(.NUM_OUTS(4), .DATA_WIDTH(32)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  rv_rr_dispatcher #(.NUM_OUTS(3), .DATA_WIDTH(8)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slot model: each channel is a one-deep buffer, ptr names the next
  // channel in rotation to try.
  bit        m_valid[4];
  bit [31:0] m_data[4];
  int        m_ptr  = 0;
  int        m_last = 0;
  int        mg, mc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        m_valid[c] <= 1'b0;
        m_data[c]  <= '0;
      end
      m_ptr  <= 0;
      m_last <= 0;
    end else begin
      mg = -1;
      for (int k = 0; k < 4; k++) begin
        mc = (m_ptr + k) % 4;
        if (mg < 0 && (!m_valid[mc] || b4.ready_out[mc])) mg = mc;
      end
      if (b4.flush) begin
        for (int c = 0; c < 4; c++) m_valid[c] <= 1'b0;
        m_ptr  <= 0;
        m_last <= 0;
      end else begin
        for (int c = 0; c < 4; c++)
          if (m_valid[c] && b4.ready_out[c]) m_valid[c] <= 1'b0;
        if (b4.valid_in && mg >= 0) begin
          m_valid[mg] <= 1'b1;
          m_data[mg]  <= b4.data_in;
          m_ptr       <= (mg + 1) % 4;
          m_last      <= mg;
        end
      end
    end
  end

  bit exp_ready;
  always @(negedge clk) begin
    if (!reset) begin
      exp_ready = 1'b0;
      for (int c = 0; c < 4; c++)
        if (!m_valid[c] || b4.ready_out[c]) exp_ready = 1'b1;
      chk("mdl_ready_in", 64'(b4.ready_in), 64'(exp_ready));
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("mdl_valid_out[%0d]", c), 64'(b4.valid_out[c]), 64'(m_valid[c]));
        chk($sformatf("mdl_data_out[%0d]", c), 64'(b4.data_out[c*32 +: 32]), 64'(m_data[c]));
      end
      chk("mdl_last_index", 64'(b4.last_index), 64'(m_last));
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] ro, input logic fl);
    b4.valid_in  = v;
    b4.data_in   = d;
    b4.ready_out = ro;
    b4.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic v, input logic [7:0] d, input logic [2:0] ro);
    b3.valid_in  = v;
    b3.data_in   = d;
    b3.ready_out = ro;
    b3.flush     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    b4.valid_in = 0; b4.data_in = '0; b4.ready_out = '0; b4.flush = 0;
    b3.valid_in = 0; b3.data_in = '0; b3.ready_out = '0; b3.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_in", 64'(b4.ready_in), 64'd1);
    chk("rst_valid_out", 64'(b4.valid_out), 64'd0);
    chk("rst_data_out", 64'(b4.data_out[31:0]), 64'd0);
    chk("rst_last_index", 64'(b4.last_index), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // strict rotation with every channel free
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 4'hF, 1'b0);
      chk("rot_valid", 64'(b4.valid_out), 64'(4'b0001 << (i % 4)));
      chk("rot_data", 64'(b4.data_out[(i % 4)*32 +: 32]), 64'(32'h10 + 32'(i)));
      chk("rot_last", 64'(b4.last_index), 64'(i % 4));
      chk("rot_ready", 64'(b4.ready_in), 64'd1);
    end
    drive(1'b0, '0, 4'hF, 1'b0);

    // ch1 stalled; rotate back round to ptr=1, then offer 0xA0
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h60 + 32'(i), 4'b1101, 1'b0);
    drive(1'b1, 32'hA0, 4'b1101, 1'b0);
    chk("skip_last", 64'(b4.last_index), 64'd2);
    chk("skip_data2", 64'(b4.data_out[2*32 +: 32]), 64'hA0);
    chk("skip_data1", 64'(b4.data_out[1*32 +: 32]), 64'h61);
    chk("skip_valid", 64'(b4.valid_out), 64'b0110);
    drive(1'b1, 32'hA1, 4'b1101, 1'b0);
    chk("skip_next_last", 64'(b4.last_index), 64'd3);
    drive(1'b0, '0, 4'hF, 1'b0);

    // fill all slots under backpressure
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hB0 + 32'(i), 4'h0, 1'b0);
    chk("full_ready", 64'(b4.ready_in), 64'd0);
    chk("full_valid", 64'(b4.valid_out), 64'hF);
    drive(1'b1, 32'hBF, 4'h0, 1'b0);
    chk("full_hold_data0", 64'(b4.data_out[31:0]), 64'hB0);
    chk("full_hold_last", 64'(b4.last_index), 64'd3);
    b4.ready_out = 4'b1000;
    #1;
    chk("full_ready_ch3", 64'(b4.ready_in), 64'd1);
    drive(1'b1, 32'hC3, 4'b1000, 1'b0);
    chk("drainload_valid", 64'(b4.valid_out), 64'hF);
    chk("drainload_data3", 64'(b4.data_out[3*32 +: 32]), 64'hC3);
    chk("drainload_last", 64'(b4.last_index), 64'd3);
    drive(1'b0, '0, 4'hF, 1'b0);

    // flush with a beat on offer
    drive(1'b1, 32'hD0, 4'h0, 1'b0);
    drive(1'b1, 32'hD1, 4'h0, 1'b0);
    chk("pre_flush_valid", 64'(b4.valid_out), 64'b0011);
    drive(1'b1, 32'hDE, 4'h0, 1'b1);
    chk("flush_valid", 64'(b4.valid_out), 64'd0);
    chk("flush_last", 64'(b4.last_index), 64'd0);
    chk("flush_data2_held", 64'(b4.data_out[2*32 +: 32]), 64'hB2);
    chk("flush_data0_held", 64'(b4.data_out[31:0]), 64'hD0);
    drive(1'b1, 32'hE0, 4'hF, 1'b0);
    chk("post_flush_valid", 64'(b4.valid_out), 64'b0001);
    chk("post_flush_data0", 64'(b4.data_out[31:0]), 64'hE0);

    // asynchronous reset between edges
    drive(1'b1, 32'hF0, 4'h0, 1'b0);
    drive(1'b1, 32'hF1, 4'h0, 1'b0);
    chk("pre_rst_valid", 64'(b4.valid_out), 64'b0111);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(b4.valid_out), 64'd0);
    chk("arst_data", 64'(b4.data_out[63:0]), 64'd0);
    chk("arst_last", 64'(b4.last_index), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h77, 4'hF, 1'b0);
    chk("post_rst_valid", 64'(b4.valid_out), 64'b0001);
    chk("post_rst_data0", 64'(b4.data_out[31:0]), 64'h77);
    drive(1'b0, '0, 4'hF, 1'b0);

    // three-channel wrap: 0,1,2,0 then ptr back at 1
    for (int i = 0; i < 4; i++) begin
      drive3(1'b1, 8'(i + 1), 3'b111);
      chk("w3_valid", 64'(b3.valid_out), 64'(3'b001 << (i % 3)));
      chk("w3_data", 64'(b3.data_out[(i % 3)*8 +: 8]), 64'(i + 1));
      chk("w3_last", 64'(b3.last_index), 64'(i % 3));
    end
    drive3(1'b1, 8'h05, 3'b111);
    chk("w3_ptr_after_wrap", 64'(b3.last_index), 64'd1);
    drive3(1'b0, 8'h00, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
